// File: rtl/conv_seq_ctrl_if.sv
// Frame-buffer read port plus the engine-side bus shared by conv_seq_ctrl (master)
// and the accurate/approximate convolution engines with their pixel source (slave).
interface conv_seq_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int K_SIZE = 3
);
    logic                            pix_req;
    logic [3:0]                      pix_addr;
    logic [DATA_W-1:0]               pix_data;
    logic                            eng_start;
    logic [DATA_W-1:0]               eng_pixel;
    logic                            eng_sel;
    logic [DATA_W*K_SIZE*K_SIZE-1:0] eng_kernel;
    logic                            valid_acc;
    logic [2*DATA_W-1:0]             out_acc;
    logic                            valid_apx;
    logic [2*DATA_W-1:0]             out_apx;

    modport master (
        output pix_req, pix_addr, eng_start, eng_pixel, eng_sel, eng_kernel,
        input  pix_data, valid_acc, out_acc, valid_apx, out_apx
    );

    modport slave (
        input  pix_req, pix_addr, eng_start, eng_pixel, eng_sel, eng_kernel,
        output pix_data, valid_acc, out_acc, valid_apx, out_apx
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Frame sequencer: fetches each pixel, starts the selected convolution engine, waits for its
// result (with timeout) and streams indexed results out.
module conv_seq_ctrl #(
    parameter int DATA_W  = 8,
    parameter int K_SIZE  = 3,
    parameter int MAX_PIX = 16,
    parameter int TMO     = 15
) (
    input  logic                            clk,
    input  logic                            rst,
    conv_seq_ctrl_if.master                 bus,
    input  logic                            go,
    input  logic                            mode,
    input  logic [4:0]                      num_pix,
    input  logic [DATA_W*K_SIZE*K_SIZE-1:0] kernel_in,
    output logic                            res_valid,
    output logic [2*DATA_W-1:0]             res_data,
    output logic [3:0]                      res_idx,
    output logic                            busy,
    output logic                            done,
    output logic                            tmo_err
);
    localparam int KW    = DATA_W * K_SIZE * K_SIZE;
    localparam int TMO_W = $clog2(TMO + 1);

    typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT, EMIT, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          idx;
    logic [4:0]          count;
    logic [TMO_W-1:0]    wait_cnt;
    logic [KW-1:0]       kernel_q;
    logic                sel_q;
    logic [DATA_W-1:0]   pixel_q;
    logic [2*DATA_W-1:0] res_q;
    logic                tmo_q;

    logic                sel_valid;
    logic [2*DATA_W-1:0] sel_out;
    logic                last_pix;
    logic                wait_expired;
    logic [4:0]          num_clamped;

    // Only the engine chosen at frame start can complete a pixel; the other one is ignored.
    assign sel_valid    = sel_q ? bus.valid_apx : bus.valid_acc;
    assign sel_out      = sel_q ? bus.out_apx : bus.out_acc;
    assign last_pix     = ({1'b0, idx} == (count - 5'd1));
    assign wait_expired = (wait_cnt == TMO_W'(TMO - 1));
    assign num_clamped  = (num_pix > 5'(MAX_PIX)) ? 5'(MAX_PIX) : num_pix;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = (num_pix == 5'd0) ? DONE : FETCH;
            FETCH:   state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (sel_valid) begin
                    state_nxt = EMIT;
                end else if (wait_expired) begin
                    state_nxt = DONE;
                end
            end
            EMIT:    state_nxt = last_pix ? DONE : FETCH;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Kernel and engine select are frozen at an accepted go so mid-frame input changes cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            count    <= '0;
            wait_cnt <= '0;
            kernel_q <= '0;
            sel_q    <= 1'b0;
            pixel_q  <= '0;
            res_q    <= '0;
            tmo_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) begin
                        kernel_q <= kernel_in;
                        sel_q    <= mode;
                        count    <= num_clamped;
                        idx      <= '0;
                        tmo_q    <= 1'b0;
                    end
                end
                ISSUE: begin
                    pixel_q  <= bus.pix_data;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (sel_valid) begin
                        res_q <= sel_out;
                    end else if (wait_expired) begin
                        tmo_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                EMIT: begin
                    if (!last_pix) begin
                        idx <= idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pix_req    = (state == FETCH);
    assign bus.pix_addr   = idx;
    assign bus.eng_start  = (state == ISSUE);
    assign bus.eng_pixel  = pixel_q;
    assign bus.eng_sel    = sel_q;
    assign bus.eng_kernel = kernel_q;
    assign res_valid      = (state == EMIT);
    assign res_data       = res_q;
    assign res_idx        = idx;
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign tmo_err        = tmo_q;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Randomized scoreboard bench for conv_seq_ctrl: engine/frame-buffer models drive the bus,
// expected results are queued per frame and popped by a monitor on every res_valid.
module tb_conv_seq_ctrl;
    localparam int DATA_W = 8;
    localparam int K_SIZE = 3;
    localparam int KW     = DATA_W * K_SIZE * K_SIZE;
    localparam int TMO    = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          go = 1'b0;
    logic          mode = 1'b0;
    logic [4:0]    num_pix = '0;
    logic [KW-1:0] kernel_in = '0;
    logic          res_valid;
    logic [15:0]   res_data;
    logic [3:0]    res_idx;
    logic          busy;
    logic          done;
    logic          tmo_err;

    always #5 clk = ~clk;

    conv_seq_ctrl_if #(.DATA_W(DATA_W), .K_SIZE(K_SIZE)) bus ();

    conv_seq_ctrl #(.DATA_W(DATA_W), .K_SIZE(K_SIZE), .MAX_PIX(16), .TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .go        (go),
        .mode      (mode),
        .num_pix   (num_pix),
        .kernel_in (kernel_in),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_idx   (res_idx),
        .busy      (busy),
        .done      (done),
        .tmo_err   (tmo_err)
    );

    typedef struct {
        int          idx;
        logic [15:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [7:0]    buf_mem[16];
    int            compared = 0;
    int            mismatched = 0;
    int            pix_req_cnt = 0;
    int            eng_start_cnt = 0;
    int            res_cnt = 0;
    int            frame_k = 1;
    bit            frame_mode = 1'b0;
    bit            frame_silent = 1'b0;
    bit            acc_stuck = 1'b0;
    bit            spurious_en = 1'b0;
    int            cur_cnt = 0;
    int            cur_exp_done = 0;
    logic [KW-1:0] cur_kern = '0;

    function automatic logic [15:0] acc_model(input logic [7:0] p, input logic [KW-1:0] kern);
        return 16'(p * kern[7:0]) + {8'h00, kern[15:8]};
    endfunction

    function automatic logic [15:0] apx_model(input logic [7:0] p, input logic [KW-1:0] kern);
        return {p, kern[7:0]} ^ {kern[15:8], kern[71:64]};
    endfunction

    task automatic checkOutput(input string name, input logic [KW-1:0] actual, input logic [KW-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"},       KW'(busy), '0);
        checkOutput({tag, "_done"},       KW'(done), '0);
        checkOutput({tag, "_pix_req"},    KW'(bus.pix_req), '0);
        checkOutput({tag, "_pix_addr"},   KW'(bus.pix_addr), '0);
        checkOutput({tag, "_eng_start"},  KW'(bus.eng_start), '0);
        checkOutput({tag, "_eng_pixel"},  KW'(bus.eng_pixel), '0);
        checkOutput({tag, "_eng_sel"},    KW'(bus.eng_sel), '0);
        checkOutput({tag, "_eng_kernel"}, bus.eng_kernel, '0);
        checkOutput({tag, "_res_valid"},  KW'(res_valid), '0);
        checkOutput({tag, "_res_data"},   KW'(res_data), '0);
        checkOutput({tag, "_res_idx"},    KW'(res_idx), '0);
        checkOutput({tag, "_tmo_err"},    KW'(tmo_err), '0);
    endtask

    // Pixel source: data appears only in the cycle after pix_req, garbage otherwise.
    always @(negedge clk) begin : fb_model
        static bit         fb_pending = 1'b0;
        static logic [3:0] fb_addr = '0;
        if (rst) begin
            fb_pending   = 1'b0;
            bus.pix_data = '0;
        end else if (fb_pending) begin
            bus.pix_data = buf_mem[fb_addr];
            fb_pending   = 1'b0;
        end else begin
            bus.pix_data = 8'($urandom);
            if (bus.pix_req) begin
                fb_pending = 1'b1;
                fb_addr    = bus.pix_addr;
            end
        end
    end

    // Engine pair: the frame's engine answers frame_k cycles after eng_start; the other chatters randomly.
    always @(negedge clk) begin : eng_model
        static int   eng_cnt = 0;
        logic        sel_valid;
        logic [15:0] sel_out;
        logic        oth_valid;
        logic [15:0] oth_out;
        if (rst) begin
            eng_cnt       = 0;
            bus.valid_acc = 1'b0;
            bus.valid_apx = 1'b0;
            bus.out_acc   = '0;
            bus.out_apx   = '0;
        end else begin
            sel_valid = 1'b0;
            sel_out   = 16'($urandom);
            if (bus.eng_start) begin
                eng_cnt   = frame_silent ? 0 : frame_k;
                sel_valid = spurious_en && ($urandom_range(0, 1) == 1);
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    sel_valid = 1'b1;
                    sel_out   = frame_mode ? apx_model(bus.eng_pixel, bus.eng_kernel)
                                           : acc_model(bus.eng_pixel, bus.eng_kernel);
                end
            end
            oth_valid = acc_stuck ? 1'b1 : 1'($urandom_range(0, 1));
            oth_out   = 16'($urandom);
            if (frame_mode) begin
                bus.valid_apx = sel_valid; bus.out_apx = sel_out;
                bus.valid_acc = oth_valid; bus.out_acc = oth_out;
            end else begin
                bus.valid_acc = sel_valid; bus.out_acc = sel_out;
                bus.valid_apx = oth_valid; bus.out_apx = oth_out;
            end
        end
    end

    always @(negedge clk) begin : monitor
        static logic [15:0] last_res = '0;
        exp_t e;
        if (rst) begin
            last_res = '0;
        end else begin
            checkOutput("pulse_overlap",
                KW'((int'(bus.pix_req) + int'(bus.eng_start) + int'(res_valid) + int'(done)) > 1), '0);
            if (bus.pix_req) pix_req_cnt++;
            if (bus.eng_start) eng_start_cnt++;
            if (res_valid) begin
                res_cnt++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_result: got idx %0d data %0h expected none", res_idx, res_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("res_idx", KW'(res_idx), KW'(e.idx));
                    checkOutput("res_data", KW'(res_data), KW'(e.data));
                end
                last_res = res_data;
            end else begin
                checkOutput("res_data_stable", KW'(res_data), KW'(last_res));
            end
        end
    end

    task automatic startFrame(input int n, input bit m, input int k, input bit silent,
                              input bit stuck, input bit spur);
        logic [KW-1:0] kern;
        kern = KW'({$urandom, $urandom, $urandom});
        @(negedge clk);
        frame_mode   = m;
        frame_k      = k;
        frame_silent = silent;
        acc_stuck    = stuck;
        spurious_en  = spur;
        cur_kern     = kern;
        cur_cnt      = (n > 16) ? 16 : n;
        if (!silent) begin
            for (int i = 0; i < cur_cnt; i++) begin
                exp_q.push_back('{idx: i, data: m ? apx_model(buf_mem[i], kern) : acc_model(buf_mem[i], kern)});
            end
        end
        if (cur_cnt == 0)  cur_exp_done = 1;
        else if (silent)   cur_exp_done = 2 + TMO + 1;
        else               cur_exp_done = cur_cnt * (k + 3) + 1;
        pix_req_cnt   = 0;
        eng_start_cnt = 0;
        res_cnt       = 0;
        rst           = 1'b0;
        go            = 1'b1;
        mode          = m;
        num_pix       = n[4:0];
        kernel_in     = kern;
    endtask

    task automatic applyStimulus(input int n, input bit m, input int k, input bit silent,
                                 input bit stuck, input bit spur);
        int cyc;
        bit seen_done;
        int exp_fetch;
        startFrame(n, m, k, silent, stuck, spur);
        cyc       = 0;
        seen_done = 1'b0;
        while (!seen_done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (done) seen_done = 1'b1;
            go        = done ? 1'b0 : 1'($urandom_range(0, 1));
            mode      = 1'($urandom);
            num_pix   = 5'($urandom);
            kernel_in = KW'({$urandom, $urandom, $urandom});
        end
        go = 1'b0;
        exp_fetch = (silent && cur_cnt > 0) ? 1 : cur_cnt;
        checkOutput("done_latency", KW'(seen_done ? cyc : 0), KW'(cur_exp_done));
        checkOutput("tmo_err", KW'(tmo_err), KW'(silent && cur_cnt > 0));
        checkOutput("busy_in_done", KW'(busy), KW'(1));
        checkOutput("eng_kernel", bus.eng_kernel, cur_kern);
        checkOutput("eng_sel", KW'(bus.eng_sel), KW'(m));
        checkOutput("pix_req_count", KW'(pix_req_cnt), KW'(exp_fetch));
        checkOutput("eng_start_count", KW'(eng_start_cnt), KW'(exp_fetch));
        checkOutput("res_count", KW'(res_cnt), KW'(silent ? 0 : cur_cnt));
        checkOutput("queue_drained", KW'(exp_q.size()), '0);
        exp_q.delete();
        @(negedge clk);
        checkOutput("idle_busy", KW'(busy), '0);
        checkOutput("idle_done", KW'(done), '0);
        checkOutput("tmo_sticky", KW'(tmo_err), KW'(silent && cur_cnt > 0));
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        @(negedge clk);
        checkResetOutputs("reset");

        buf_mem[0] = 8'd10; buf_mem[1] = 8'd50; buf_mem[2] = 8'd200;
        applyStimulus(3, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        applyStimulus(3, 1'b1, 2, 1'b0, 1'b1, 1'b0);
        applyStimulus(0, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        applyStimulus(4, 1'b0, 2, 1'b1, 1'b0, 1'b1);
        applyStimulus(2, 1'b0, TMO, 1'b0, 1'b0, 1'b1);

        buf_mem = '{8'd10, 8'd50, 8'd200, 8'd255, 8'd128, 8'd64, 8'd15, 8'd90,
                    8'd30, 8'd70, 8'd180, 8'd220, 8'd40, 8'd110, 8'd75, 8'd5};
        applyStimulus(16, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        applyStimulus(16, 1'b1, 1, 1'b0, 1'b0, 1'b1);
        applyStimulus(31, 1'b0, 1, 1'b0, 1'b0, 1'b0);

        // Abort during WAIT of pixel 1, then restart with go on the very first edge after release.
        startFrame(3, 1'b1, 4, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        go = 1'b0;
        for (int i = 0; i < 40 && eng_start_cnt < 2; i++) @(negedge clk);
        @(negedge clk);
        checkOutput("abort_in_wait_reached", KW'(eng_start_cnt), KW'(2));
        #2 rst = 1'b1;
        #1 checkResetOutputs("abort");
        checkOutput("abort_pending_results", KW'(exp_q.size()), KW'(2));
        exp_q.delete();
        @(negedge clk);
        checkOutput("abort_no_done", KW'(done), '0);
        applyStimulus(3, 1'b0, 3, 1'b0, 1'b0, 1'b0);

        for (int f = 0; f < 24; f++) begin
            for (int i = 0; i < 16; i++) buf_mem[i] = 8'($urandom);
            applyStimulus($urandom_range(0, 31), 1'($urandom), $urandom_range(1, 6),
                          $urandom_range(0, 7) == 0, 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 Parameters (name, default, meaning): DATA_W, 8, pixel width; K_SIZE, 3, kernel dimension; MAX_PIX, 16, frame buffer depth; TMO, 15, maximum WAIT cycles before timeout.
REQ-002 Ports (name direction width meaning): clk in 1 clock; rst in 1 reset, asynchronous, active-high.
REQ-003 go in 1: start-of-frame request; mode in 1: 0 = accurate engine, 1 = approximate engine; num_pix in 5: pixel count, 0..16.
REQ-004 kernel_in in DATA_W*K_SIZE*K_SIZE: kernel coefficients; eng_kernel out DATA_W*K_SIZE*K_SIZE: held kernel to both engines.
REQ-005 pix_req out 1, pix_addr out 4: frame buffer read strobe and address; pix_data in DATA_W: read data, valid the cycle after pix_req.
REQ-006 eng_start out 1, eng_pixel out DATA_W: engine start pulse and pixel; eng_sel out 1: registered mode.
REQ-007 valid_acc in 1, out_acc in 2*DATA_W, valid_apx in 1, out_apx in 2*DATA_W: engine results.
REQ-008 res_valid out 1, res_data out 2*DATA_W, res_idx out 4: result stream; busy out 1; done out 1; tmo_err out 1.

Function
REQ-009 States: IDLE, FETCH, ISSUE, WAIT, EMIT, DONE; exactly one active per cycle.
REQ-010 IDLE: go=1, num_pix in 1..16 -> FETCH; in the same edge, latch kernel_in to eng_kernel, mode to eng_sel, num_pix to the count register, clear idx to 0, clear tmo_err.
REQ-011 IDLE: go=1, num_pix=0 -> DONE directly; no pix_req, no eng_start, no res_valid.
REQ-012 IDLE: num_pix>16 -> treated as 16.
REQ-013 go outside IDLE: ignored; eng_kernel and eng_sel stay unchanged until the next accepted go.
REQ-014 FETCH, one cycle: pix_req=1, pix_addr=idx -> ISSUE.
REQ-015 ISSUE, one cycle: eng_pixel <= pix_data; eng_start=1 for exactly this cycle -> WAIT; clear the wait counter.
REQ-016 WAIT: sample only the valid selected by eng_sel (valid_acc if 0, valid_apx if 1). Ignore the unselected valid. Ignore any valid seen during ISSUE.
REQ-017 WAIT, selected valid=1 -> EMIT; latch the matching out_* into res_data.
REQ-018 WAIT, no valid: wait counter increments; when counter reaches TMO with no valid -> set tmo_err (sticky until next accepted go) -> DONE; no res_valid for that pixel.
REQ-019 EMIT, one cycle: res_valid=1, res_idx=idx, res_data held. If idx=count-1 -> DONE; else idx+1 -> FETCH.
REQ-020 DONE, one cycle: done=1 -> IDLE.
REQ-021 busy=1 in every state except IDLE.
REQ-022 Per-pixel latency: FETCH + ISSUE + k WAIT cycles + EMIT = k+3 cycles, where k = engine latency counted from eng_start (k>=1).
REQ-023 Frame latency: go edge to done = count*(k+3)+1 cycles.
REQ-024 res_data stays stable between EMIT pulses. idx wraps only via the count compare and never exceeds 15.
REQ-025 pix_req, eng_start, res_valid and done are single-cycle pulses and never overlap one another.

Reset
REQ-026 rst=1 asynchronously forces IDLE. All outputs go to 0: busy, done, pix_req, pix_addr, eng_start, eng_pixel, eng_sel, eng_kernel, res_valid, res_data, res_idx, tmo_err. Internal idx, count and wait counter also go to 0.
REQ-027 rst asserted mid-frame aborts the frame; no done is emitted. After release, the block accepts go on the first clk edge.

Verification
REQ-028 Engine model with k=2; mode=0; num_pix=3; buffer = 10, 50, 200 -> three res_valid, res_idx 0, 1, 2, each res_data = model out_acc; done 16 cycles after go; tmo_err=0.
REQ-029 Same stimulus with mode=1 and valid_acc stuck at 1 -> results taken only from out_apx; eng_sel=1 throughout; valid_acc has no effect.
REQ-030 num_pix=0 -> done 1 cycle after go; no pix_req, eng_start or res_valid.
REQ-031 Engine never asserts valid; num_pix=4 -> tmo_err=1 after 15 WAIT cycles; done pulses; zero res_valid.
REQ-032 num_pix=16, buffer = 10, 50, 200, 255, 128, 64, 15, 90, 30, 70, 180, 220, 40, 110, 75, 5 -> 16 results with res_idx 0..15 in order; pix_addr never exceeds 15; then a second go with a new kernel_in -> eng_kernel updates.
REQ-033 rst pulsed during WAIT of pixel 1 -> all outputs 0 immediately; no done; a fresh go afterwards runs a complete frame from idx 0.
